// File: rtl/ras_ckpt.sv
// Return-address stack with per-entry recursion counters and checkpoint/restore.
// Circular buffer: overflow overwrites the oldest entry and raises a one-cycle flag.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ras_ckpt #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int CNT_WIDTH  = 8,
   localparam int DW        = $clog2(DEPTH),
   localparam int CKPT_W    = DW + (DW + 1) + ADDR_WIDTH + CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] bp_ras_addr,
   input  logic                  bp_ras_push,
   input  logic                  bp_ras_pop,
   input  logic                  bp_ras_restore,
   input  logic [CKPT_W-1:0]     bp_ras_ckpt_in,
   output logic [ADDR_WIDTH-1:0] ras_bp_addr,
   output logic                  ras_bp_valid,
   output logic [CKPT_W-1:0]     ras_bp_ckpt,
   output logic                  ras_csrf_ras_full_add
);

   localparam logic [DW:0]          OCC_FULL = (DW + 1)'(DEPTH);
   localparam logic [DW:0]          OCC_ZERO = {(DW + 1){1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
   logic [CNT_WIDTH-1:0]  cnt_q  [DEPTH];
   logic [CNT_WIDTH-1:0]  cnt_d  [DEPTH];
   logic [DW-1:0]         top_q, top_d;
   logic [DW:0]           occ_q, occ_d;
   logic                  full_q, full_d;

   logic [ADDR_WIDTH-1:0] top_addr_s;
   logic [CNT_WIDTH-1:0]  top_cnt_s;
   logic [DW-1:0]         top_inc_s, top_dec_s;
   logic                  empty_s, match_s;
   logic [DW-1:0]         ck_top_s;
   logic [DW:0]           ck_occ_s;
   logic [ADDR_WIDTH-1:0] ck_addr_s;
   logic [CNT_WIDTH-1:0]  ck_cnt_s;

   assign top_addr_s = addr_q[top_q];
   assign top_cnt_s  = cnt_q[top_q];
   assign top_inc_s  = top_q + DW'(1);
   assign top_dec_s  = top_q - DW'(1);
   assign empty_s    = (occ_q == OCC_ZERO);
   assign match_s    = (bp_ras_addr == top_addr_s);

   assign ck_top_s  = bp_ras_ckpt_in[CKPT_W-1 -: DW];
   assign ck_occ_s  = bp_ras_ckpt_in[CKPT_W-DW-1 -: DW + 1];
   assign ck_addr_s = bp_ras_ckpt_in[CNT_WIDTH +: ADDR_WIDTH];
   assign ck_cnt_s  = bp_ras_ckpt_in[CNT_WIDTH-1:0];

   assign ras_bp_valid          = !empty_s;
   assign ras_bp_addr           = empty_s ? {ADDR_WIDTH{1'b0}} : top_addr_s;
   assign ras_bp_ckpt           = {top_q, occ_q, top_addr_s, top_cnt_s};
   assign ras_csrf_ras_full_add = full_q;

   // Next-state: restore beats push/pop; allocation past a full stack wraps onto the oldest slot.
   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      top_d  = top_q;
      occ_d  = occ_q;
      full_d = 1'b0;
      if (bp_ras_restore) begin
         top_d           = ck_top_s;
         occ_d           = ck_occ_s;
         addr_d[ck_top_s] = ck_addr_s;
         cnt_d[ck_top_s]  = ck_cnt_s;
      end else if (bp_ras_push && empty_s) begin
         top_d            = top_inc_s;
         addr_d[top_inc_s] = bp_ras_addr;
         cnt_d[top_inc_s]  = CNT_ONE;
         occ_d            = CNT_ONE[0] ? (DW + 1)'(1) : OCC_ZERO;
      end else if (bp_ras_push && !bp_ras_pop) begin
         if (match_s && (top_cnt_s != CNT_MAX)) begin
            cnt_d[top_q] = top_cnt_s + CNT_ONE;
         end else begin
            top_d             = top_inc_s;
            addr_d[top_inc_s] = bp_ras_addr;
            cnt_d[top_inc_s]  = CNT_ONE;
            occ_d             = (occ_q == OCC_FULL) ? OCC_FULL : occ_q + (DW + 1)'(1);
            full_d            = (occ_q == OCC_FULL);
         end
      end else if (bp_ras_pop && !bp_ras_push) begin
         if (empty_s) begin
            occ_d = occ_q;
         end else if (top_cnt_s > CNT_ONE) begin
            cnt_d[top_q] = top_cnt_s - CNT_ONE;
         end else begin
            top_d = top_dec_s;
            occ_d = occ_q - (DW + 1)'(1);
         end
      end else if (bp_ras_push && bp_ras_pop) begin
         if (match_s) begin
            occ_d = occ_q;
         end else if (top_cnt_s > CNT_ONE) begin
            // Return consumes one recursion level, then the new call lands above it.
            cnt_d[top_q]      = top_cnt_s - CNT_ONE;
            top_d             = top_inc_s;
            addr_d[top_inc_s] = bp_ras_addr;
            cnt_d[top_inc_s]  = CNT_ONE;
            occ_d             = (occ_q == OCC_FULL) ? OCC_FULL : occ_q + (DW + 1)'(1);
            full_d            = (occ_q == OCC_FULL);
         end else begin
            addr_d[top_q] = bp_ras_addr;
            cnt_d[top_q]  = CNT_ONE;
         end
      end else begin
         occ_d = occ_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= {ADDR_WIDTH{1'b0}};
            cnt_q[i]  <= {CNT_WIDTH{1'b0}};
         end
         top_q  <= {DW{1'b0}};
         occ_q  <= OCC_ZERO;
         full_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         top_q  <= top_d;
         occ_q  <= occ_d;
         full_q <= full_d;
      end
   end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed table-driven bench for ras_ckpt (DEPTH=4, CNT_WIDTH=2, ADDR_WIDTH=32).
module tb_ras_ckpt;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int CW    = 2;
   localparam int CKW   = 2 + 3 + AW + CW;

   logic           clk;
   logic           rst;
   logic [AW-1:0]  addr;
   logic           push, pop, restore;
   logic [CKW-1:0] ckpt_in;
   logic [AW-1:0]  o_addr;
   logic           o_valid;
   logic [CKW-1:0] o_ckpt;
   logic           o_full;

   int tests = 0;
   int fails = 0;

   ras_ckpt #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .bp_ras_addr           (addr),
      .bp_ras_push           (push),
      .bp_ras_pop            (pop),
      .bp_ras_restore        (restore),
      .bp_ras_ckpt_in        (ckpt_in),
      .ras_bp_addr           (o_addr),
      .ras_bp_valid          (o_valid),
      .ras_bp_ckpt           (o_ckpt),
      .ras_csrf_ras_full_add (o_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic           rst, push, pop, restore;
      logic [AW-1:0]  addr;
      logic [CKW-1:0] ckpt_in;
      logic [CKW-1:0] exp_ckpt;
      logic           exp_full;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [CKW-1:0] mk(input logic [1:0] t, input logic [2:0] o,
                                        input logic [AW-1:0] a, input logic [CW-1:0] c);
      return {t, o, a, c};
   endfunction

   task automatic add(input logic r, input logic p, input logic q, input logic s,
                      input logic [AW-1:0] a, input logic [CKW-1:0] ci,
                      input logic [CKW-1:0] ec, input logic ef);
      vec_t tv;
      tv.rst = r; tv.push = p; tv.pop = q; tv.restore = s;
      tv.addr = a; tv.ckpt_in = ci; tv.exp_ckpt = ec; tv.exp_full = ef;
      vecs.push_back(tv);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic p, input logic q, input logic s,
                       input logic [AW-1:0] a, input logic [CKW-1:0] ci);
      rst = r; push = p; pop = q; restore = s; addr = a; ckpt_in = ci;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [CKW-1:0] ec, input logic ef);
      logic          ev;
      logic [AW-1:0] ea;
      ev = (ec[AW+CW+2 -: 3] != 3'd0);
      ea = ev ? ec[CW +: AW] : {AW{1'b0}};
      chk({tag, ".valid"}, 64'(o_valid), 64'(ev));
      chk({tag, ".addr"},  64'(o_addr),  64'(ea));
      chk({tag, ".ckpt"},  64'(o_ckpt),  64'(ec));
      chk({tag, ".full"},  64'(o_full),  64'(ef));
   endtask

   localparam logic [CKW-1:0] Z = {CKW{1'b0}};

   initial begin
      rst = 1'b0; push = 1'b0; pop = 1'b0; restore = 1'b0;
      addr = 32'h0; ckpt_in = Z;

      //   rst   push  pop   rest  addr        ckpt_in               expected ckpt            full
      add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     Z,                    Z,                       1'b0);
      // basic push/pop and empty pop
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   Z,                    mk(2'd1,3'd1,32'h100,2'd1), 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h200,   Z,                    mk(2'd2,3'd2,32'h200,2'd1), 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd1,3'd1,32'h100,2'd1), 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    Z,                       1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    Z,                       1'b0);
      // recursion counter saturation
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   Z,                    mk(2'd1,3'd1,32'h100,2'd1), 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   Z,                    mk(2'd1,3'd1,32'h100,2'd2), 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   Z,                    mk(2'd1,3'd1,32'h100,2'd3), 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   Z,                    mk(2'd2,3'd2,32'h100,2'd1), 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   Z,                    mk(2'd2,3'd2,32'h100,2'd2), 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd2,3'd2,32'h100,2'd1), 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd1,3'd1,32'h100,2'd3), 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd1,3'd1,32'h100,2'd2), 1'b0);
      // overflow
      add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     Z,                    Z,                       1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h1,     Z,                    mk(2'd1,3'd1,32'h1,2'd1),   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h2,     Z,                    mk(2'd2,3'd2,32'h2,2'd1),   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h3,     Z,                    mk(2'd3,3'd3,32'h3,2'd1),   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h4,     Z,                    mk(2'd0,3'd4,32'h4,2'd1),   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h5,     Z,                    mk(2'd1,3'd4,32'h5,2'd1),   1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd0,3'd3,32'h4,2'd1),   1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd3,3'd2,32'h3,2'd1),   1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd2,3'd1,32'h2,2'd1),   1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd1,3'd0,32'h5,2'd1),   1'b0);
      // checkpoint and restore
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'hA,     Z,                    mk(2'd2,3'd1,32'hA,2'd1),   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'hB,     Z,                    mk(2'd3,3'd2,32'hB,2'd1),   1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd2,3'd1,32'hA,2'd1),   1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd1,3'd0,32'h5,2'd1),   1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,     mk(2'd2,3'd1,32'hA,2'd1), mk(2'd2,3'd1,32'hA,2'd1), 1'b0);
      // simultaneous push and pop
      add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     Z,                    Z,                       1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h10,    Z,                    mk(2'd1,3'd1,32'h10,2'd1),  1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h10,    Z,                    mk(2'd1,3'd1,32'h10,2'd2),  1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 32'h20,    Z,                    mk(2'd2,3'd2,32'h20,2'd1),  1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     Z,                    mk(2'd1,3'd1,32'h10,2'd1),  1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 32'h10,    Z,                    mk(2'd1,3'd1,32'h10,2'd1),  1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 32'h30,    Z,                    mk(2'd1,3'd1,32'h30,2'd1),  1'b0);
      // restore priority
      add(1'b1, 1'b1, 1'b0, 1'b1, 32'h55,    mk(2'd2,3'd1,32'hA,2'd1), Z,                   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 32'h55,    mk(2'd3,3'd2,32'h77,2'd2), mk(2'd3,3'd2,32'h77,2'd2), 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h1,     Z,                    mk(2'd0,3'd3,32'h1,2'd1),   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h2,     Z,                    mk(2'd1,3'd4,32'h2,2'd1),   1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 32'h9,     mk(2'd1,3'd4,32'h2,2'd1), mk(2'd1,3'd4,32'h2,2'd1), 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].restore, vecs[i].addr, vecs[i].ckpt_in);
         check_all($sformatf("vec%0d", i), vecs[i].exp_ckpt, vecs[i].exp_full);
      end

      // Reset held two cycles while a push is requested, then a single push.
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h7, Z);
      check_all("rsthold0", Z, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h7, Z);
      check_all("rsthold1", Z, 1'b0);
      // Saturate one entry, then unwind it with pops.
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 32'h7, Z);
         check_all($sformatf("sat_push%0d", k), mk(2'd1, 3'd1, 32'h7, 2'(k)), 1'b0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, Z);
      check_all("unwind0", mk(2'd1, 3'd1, 32'h7, 2'd2), 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, Z);
      check_all("unwind1", mk(2'd1, 3'd1, 32'h7, 2'd1), 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, Z);
      check_all("unwind2", mk(2'd0, 3'd0, 32'h0, 2'd0), 1'b0);
      // Full stack, push+pop with cnt>1 at top: overflow pulse expected.
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, Z);
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'(k), Z);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h4, Z);
      check_all("pp_pre", mk(2'd0, 3'd4, 32'h4, 2'd2), 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h9, Z);
      check_all("pp_ovf", mk(2'd1, 3'd4, 32'h9, 2'd1), 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, Z);
      check_all("pp_pop", mk(2'd0, 3'd3, 32'h4, 2'd1), 1'b0);

      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, Z);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
